// File: rtl/otl_word_fifo.sv
// First-word-fall-through FIFO for packed sample words; drops and counts words offered while full.
// Optional OTL_FIFO_LAST_EN adds a pop-driven burst counter that flags the final word of each burst on last_o.
module otl_word_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int BURST_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   data_i,
  input  logic          frame_i,
  input  logic          clr_i,
  output logic [31:0]   data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic [15:0]   drop_cnt_o,
  output logic          last_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if (DEPTH != (1 << AW) || DEPTH < 4 || BURST_LEN < 1) begin : g_bad_cfg
    $error("otl_word_fifo: DEPTH must equal 2**AW and be >= 4; BURST_LEN must be >= 1");
  end

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full = (level_q == FULL_LVL);
    pop  = (level_q != '0) & ready_i;
    // A pop frees the head slot this cycle, so a full FIFO can still take a word.
    push = frame_i & (~full | pop);
    drop = frame_i & full & ~pop;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_i) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign valid_o    = (level_q != '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

`ifdef OTL_FIFO_LAST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (pop) begin
      burst_cnt_d = (burst_cnt_q == BURST_LAST) ? '0 : burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign last_o = valid_o & (burst_cnt_q == BURST_LAST);
`else
  assign last_o = 1'b0;
`endif

endmodule

// File: tb/tb_otl_word_fifo.sv
// Randomized and directed bench for otl_word_fifo against a queue-based reference model.
module tb_otl_word_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BL    = 4;

  logic          clk = 1'b0;
  logic          rst, frame_i, clr_i, ready_i;
  logic [31:0]   data_i, data_o;
  logic          valid_o, overflow_o, last_o;
  logic [AW:0]   level_o;
  logic [15:0]   drop_cnt_o;

  otl_word_fifo #(.DEPTH(DEPTH), .AW(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .frame_i(frame_i), .clr_i(clr_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_drops;
  int          m_pops;
  int          last_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_last();
`ifdef OTL_FIFO_LAST_EN
    return (mq.size() != 0) && ((m_pops % BL) == BL - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    chk("level", 32'(level_o), 32'(mq.size()));
    chk("valid", 32'(valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("data", data_o, mq[0]);
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drops));
    chk("last", 32'(last_o), 32'(exp_last()));
    if (last_o === 1'b1) last_seen++;
  endtask

  // Inputs applied at the falling edge, model advanced at the rising edge, outputs checked at the next falling edge.
  task automatic cycle(input bit r, input bit f, input logic [31:0] d, input bit rdy, input bit c);
    bit pop, full, drop;
    rst = r; frame_i = f; data_i = d; ready_i = rdy; clr_i = c;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0; m_drops = 0; m_pops = 0;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      full = (mq.size() == DEPTH);
      drop = f && full && !pop;
      if (pop) begin
        void'(mq.pop_front());
        m_pops++;
      end
      if (f && !drop) mq.push_back(d);
      if (drop) begin
        m_ovf = 1'b1;
        m_drops = c ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
      end else if (c) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; frame_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0; data_i = '0;
    mq.delete(); m_ovf = 0; m_drops = 0; m_pops = 0; last_seen = 0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_level", 32'(level_o), 0);
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_ovf", 32'(overflow_o), 0);
    chk("reset_drop", 32'(drop_cnt_o), 0);

    // Three words streamed straight through.
    cycle(0, 1, 32'hAAAA_0001, 1, 0);
    chk("t1_fwft_a", data_o, 32'hAAAA_0001);
    cycle(0, 1, 32'hBBBB_0002, 1, 0);
    cycle(0, 1, 32'hCCCC_0003, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    chk("t1_level", 32'(level_o), 0);

    // Overfill with consumer stalled.
    for (int i = 0; i < DEPTH + 3; i++) cycle(0, 1, 32'h1000_0000 + 32'(i), 0, 0);
    chk("t2_level", 32'(level_o), DEPTH);
    chk("t2_ovf", 32'(overflow_o), 1);
    chk("t2_drop", 32'(drop_cnt_o), 3);
    chk("t2_head", data_o, 32'h1000_0000);

    // Full with simultaneous push and pop: no drop.
    cycle(0, 1, 32'h3333_3333, 1, 0);
    chk("t3_level", 32'(level_o), DEPTH);
    chk("t3_drop", 32'(drop_cnt_o), 3);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 1, 0);

    // Reset with words buffered.
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h5000_0000 + 32'(i), 0, 0);
    chk("t5_level_pre", 32'(level_o), 5);
    cycle(1, 0, 0, 0, 0);
    chk("t5_level", 32'(level_o), 0);
    chk("t5_valid", 32'(valid_o), 0);
    chk("t5_drop", 32'(drop_cnt_o), 0);

    // Burst marker over an 8-word stream.
    last_seen = 0;
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h6000_0000 + 32'(i), 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0);
`ifdef OTL_FIFO_LAST_EN
    chk("t6_last_count", 32'(last_seen), 2);
`else
    chk("t6_last_count", 32'(last_seen), 0);
`endif

    // Drop counter saturation, then clear racing a drop.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, $urandom, 0, 0);
    for (int i = 0; i < 65540; i++) cycle(0, 1, $urandom, 0, 0);
    chk("t4_sat", 32'(drop_cnt_o), 32'hFFFF);
    cycle(0, 1, 32'hDEAD_BEEF, 0, 1);
    chk("t4_clr_drop_cnt", 32'(drop_cnt_o), 1);
    chk("t4_clr_drop_ovf", 32'(overflow_o), 1);
    cycle(0, 0, 0, 0, 1);
    chk("t4_clr_cnt", 32'(drop_cnt_o), 0);
    chk("t4_clr_ovf", 32'(overflow_o), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 60),
            $urandom,
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
